// File: rtl/bcd_alu_pkg.sv
`default_nettype none
// =============================================================================
// Package     : bcd_alu_pkg
// Description : Operation codes, FSM state encoding and error fill for the
//               sequential BCD ALU.
// Revision    : 1.0 - initial release
// =============================================================================
package bcd_alu_pkg;

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_mul = 2'b10;
    localparam logic [1:0] c_op_div = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDSUB    = 3'd1,
        MUL_SHIFT = 3'd2,
        MUL_ADD   = 3'd3,
        DIV_SHIFT = 3'd4,
        DIV_SUB   = 3'd5,
        DONE      = 3'd6
    } state_t;

    // Every result nibble is filled with this value on an error
    localparam logic [3:0] c_err_digit = 4'hF;

endpackage
`default_nettype wire

// File: rtl/bcd_alu_seq_if.sv
`default_nettype none
// =============================================================================
// Interface   : bcd_alu_seq_if
// Description : Request/response bundle of the sequential BCD ALU.
// Revision    : 1.0 - initial release
// =============================================================================
interface bcd_alu_seq_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic [1:0]            op;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic [8*DIGITS-1:0]   result;
    logic                  status;
    logic                  busy;
    logic                  done;

    modport master (output start, op, a, b, input result, status, busy, done);
    modport slave  (input start, op, a, b, output result, status, busy, done);
endinterface
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// =============================================================================
// Module      : bcd_digit_add
// Description : One-digit BCD adder; sub mode adds the nines' complement of b.
// Revision    : 1.0 - initial release
// =============================================================================
module bcd_digit_add (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    input  wire logic       cin,
    input  wire logic       sub,
    output logic      [3:0] sum,
    output logic            cout
);
    logic [3:0] w_b;
    logic [4:0] w_bin;

    always_comb begin
        w_b   = sub ? (4'd9 - b) : b;
        w_bin = {1'b0, a} + {1'b0, w_b} + {4'b0000, cin};
        if (w_bin > 5'd9) begin
            sum  = w_bin[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            sum  = w_bin[3:0];
            cout = 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bcd_alu_seq.sv
`default_nettype none
// =============================================================================
// Module      : bcd_alu_seq
// Description : Sequential BCD add/sub/mul/div over one shared digit-adder chain.
// Revision    : 1.0 - initial release
// =============================================================================
module bcd_alu_seq #(
    parameter int DIGITS = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    bcd_alu_seq_if.slave bus
);
    import bcd_alu_pkg::*;

    localparam int W  = 4 * DIGITS;
    localparam int CW = 8 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          r_state, w_next;
    logic [1:0]      r_op;
    logic [W-1:0]    r_a, r_b, r_q;
    logic [CW-1:0]   r_acc, r_result;
    logic [W+3:0]    r_rem;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_cnt;
    logic            r_status;

    logic [CW-1:0]   w_x, w_y, w_sum, w_res, w_acc_shl;
    logic [2*DIGITS:0] w_c;
    logic            w_sub, w_cin, w_cout, w_stat;
    logic            w_bad, w_last, w_lt, w_busy, w_done;
    logic [3:0]      w_bdig, w_adig;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) w_bad = 1'b1;
        end
    end

    assign w_last    = (r_idx == '0);
    assign w_bdig    = r_b[{r_idx, 2'b00} +: 4];
    assign w_adig    = r_a[{r_idx, 2'b00} +: 4];
    assign w_lt      = (r_a < r_b);
    assign w_acc_shl = r_acc << 4;

    // Subtract always runs max-min so the chain never has to re-complement
    always_comb begin
        w_x   = '0;
        w_y   = '0;
        w_sub = 1'b0;
        w_cin = 1'b0;
        case (r_state)
            ADDSUB: begin
                if (r_op == c_op_sub) begin
                    w_sub = 1'b1;
                    w_cin = 1'b1;
                    w_x[W-1:0] = w_lt ? r_b : r_a;
                    w_y[W-1:0] = w_lt ? r_a : r_b;
                end else begin
                    w_x[W-1:0] = r_a;
                    w_y[W-1:0] = r_b;
                end
            end
            MUL_ADD: begin
                w_x        = r_acc;
                w_y[W-1:0] = r_a;
            end
            DIV_SUB: begin
                w_x[W+3:0] = r_rem;
                w_y[W-1:0] = r_b;
                w_sub      = 1'b1;
                w_cin      = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_c[0] = w_cin;
    for (genvar i = 0; i < 2*DIGITS; i++) begin : g_chain
        bcd_digit_add u_digit (
            .a    (w_x[4*i +: 4]),
            .b    (w_y[4*i +: 4]),
            .cin  (w_c[i]),
            .sub  (w_sub),
            .sum  (w_sum[4*i +: 4]),
            .cout (w_c[i+1])
        );
    end
    assign w_cout = w_c[2*DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_bad)                  w_next = DONE;
                    else if (bus.op == c_op_mul) w_next = MUL_SHIFT;
                    else if (bus.op == c_op_div) w_next = (bus.b == '0) ? DONE : DIV_SHIFT;
                    else                        w_next = ADDSUB;
                end
            end
            ADDSUB:    w_next = DONE;
            MUL_SHIFT: begin
                if (w_bdig != 4'd0) w_next = MUL_ADD;
                else if (w_last)    w_next = DONE;
                else                w_next = MUL_SHIFT;
            end
            MUL_ADD: begin
                if (r_cnt == 4'd1) w_next = w_last ? DONE : MUL_SHIFT;
            end
            DIV_SHIFT: w_next = DIV_SUB;
            DIV_SUB: begin
                if (!w_cout) w_next = w_last ? DONE : DIV_SHIFT;
            end
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE) && (r_state != DONE);
        w_done = (r_state == DONE);
    end

    // Value captured into result/status on the edge that enters DONE
    always_comb begin
        w_res  = '0;
        w_stat = 1'b0;
        case (r_state)
            IDLE: begin
                w_res  = {2*DIGITS{c_err_digit}};
                w_stat = 1'b1;
            end
            ADDSUB: begin
                w_res[W-1:0] = w_sum[W-1:0];
                w_stat       = (r_op == c_op_sub) ? w_lt : w_sum[W];
            end
            MUL_SHIFT: begin
                w_res  = w_acc_shl;
                w_stat = |w_acc_shl[CW-1:W];
            end
            MUL_ADD: begin
                w_res  = w_sum;
                w_stat = |w_sum[CW-1:W];
            end
            DIV_SUB:  w_res = {r_rem[W-1:0], r_q};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_idx <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.op;
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_acc <= '0;
                        r_rem <= '0;
                        r_q   <= '0;
                        r_idx <= IW'(DIGITS - 1);
                        r_cnt <= '0;
                    end
                end
                MUL_SHIFT: begin
                    r_acc <= w_acc_shl;
                    r_cnt <= w_bdig;
                    if (w_bdig == 4'd0 && !w_last) r_idx <= r_idx - IW'(1);
                end
                MUL_ADD: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1 && !w_last) r_idx <= r_idx - IW'(1);
                end
                DIV_SHIFT: begin
                    r_rem <= {r_rem[W-1:0], w_adig};
                    r_q   <= r_q << 4;
                end
                DIV_SUB: begin
                    // A quotient digit never exceeds 9, so a nibble increment suffices
                    if (w_cout) begin
                        r_rem <= w_sum[W+3:0];
                        r_q   <= r_q + W'(1);
                    end else if (!w_last) begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_status <= 1'b0;
        end else if (w_next == DONE && r_state != DONE) begin
            r_result <= w_res;
            r_status <= w_stat;
        end
    end

    assign bus.result = r_result;
    assign bus.status = r_status;
    assign bus.busy   = w_busy;
    assign bus.done   = w_done;

endmodule
`default_nettype wire

// File: tb/tb_bcd_alu_seq.sv
`default_nettype none
// =============================================================================
// Module      : tb_bcd_alu_seq
// Description : Directed self-checking bench for bcd_alu_seq with DIGITS=2.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_bcd_alu_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_busy;
    int   done_seen;
    logic [16:0] sb_q[$];

    bcd_alu_seq_if #(.DIGITS(2)) bus ();

    bcd_alu_seq #(.DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int b2i(input logic [7:0] v);
        return 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on decoded operands
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] r, output logic s, output int lat);
        int x, y, v, q;
        x = b2i(a);
        y = b2i(b);
        if (a[7:4] > 9 || a[3:0] > 9 || b[7:4] > 9 || b[3:0] > 9 || (op == 2'b11 && y == 0)) begin
            r = 16'hFFFF; s = 1'b1; lat = 1;
            return;
        end
        case (op)
            2'b00: begin v = x + y; r = {8'h00, i2b(v % 100)}; s = (v > 99); lat = 2; end
            2'b01: begin
                v = (x < y) ? y - x : x - y;
                r = {8'h00, i2b(v)}; s = (x < y); lat = 2;
            end
            2'b10: begin
                v = x * y; r = {i2b(v / 100), i2b(v % 100)}; s = (v > 99);
                lat = 2 + int'(b[7:4]) + int'(b[3:0]) + 1;
            end
            default: begin
                q = x / y; r = {i2b(x % y), i2b(q)}; s = 1'b0;
                lat = 4 + q / 10 + q % 10 + 1;
            end
        endcase
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending request
    always @(negedge clk) begin
        logic [16:0] exp_v;
        if (!rst && bus.done) begin
            done_seen++;
            n_vec++;
            assert (sb_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_done: observed done=1, required no pending request");
            end
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                chk("result", 32'(bus.result), 32'(exp_v[15:0]));
                chk("status", 32'(bus.status), 32'(exp_v[16]));
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit glitch);
        logic [15:0] er;
        logic        es;
        int          el, cyc, bsy;
        model(op, a, b, er, es, el);
        sb_q.push_back({es, er});
        @(negedge clk);
        if (bus.done) @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        bsy = 0;
        while (!bus.done && cyc < 64) begin
            if (bus.busy) bsy++;
            if (glitch && cyc == 3) begin
                bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'h11; bus.b = 8'h22;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("latency op%0d %h/%h", op, a, b), 32'(cyc), 32'(el));
        last_busy = bsy;
    endtask

    initial begin
        rst = 1'b1;
        done_seen = 0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = 8'h00; bus.b = 8'h00;
        #12;
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_status", 32'(bus.status), 32'h0);
        chk("rst_busy",   32'(bus.busy),   32'h0);
        chk("rst_done",   32'(bus.done),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op(2'b00, 8'h45, 8'h67, 1'b0);
        do_op(2'b00, 8'h00, 8'h00, 1'b0);
        do_op(2'b00, 8'h99, 8'h99, 1'b0);
        do_op(2'b01, 8'h23, 8'h58, 1'b0);
        do_op(2'b01, 8'h58, 8'h23, 1'b0);
        do_op(2'b01, 8'h42, 8'h42, 1'b0);
        do_op(2'b10, 8'h12, 8'h34, 1'b0);
        chk("mul_busy_cycles", 32'(last_busy), 32'd9);
        do_op(2'b10, 8'h99, 8'h99, 1'b0);
        do_op(2'b10, 8'h07, 8'h10, 1'b0);
        do_op(2'b10, 8'h05, 8'h00, 1'b0);
        do_op(2'b11, 8'h99, 8'h07, 1'b0);
        do_op(2'b11, 8'h05, 8'h09, 1'b0);
        do_op(2'b11, 8'h99, 8'h01, 1'b0);
        do_op(2'b11, 8'h99, 8'h00, 1'b0);
        do_op(2'b00, 8'h1A, 8'h00, 1'b0);
        do_op(2'b10, 8'h12, 8'hA0, 1'b0);
        do_op(2'b10, 8'h12, 8'h34, 1'b1);

        // Abort a multiply: a mid-operation start is ignored, then reset kills it
        @(negedge clk);
        if (bus.done) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 8'h12; bus.b = 8'h34;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'h11; bus.b = 8'h22;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("glitch_busy", 32'(bus.busy), 32'h1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_busy",   32'(bus.busy),   32'h0);
        chk("abort_done",   32'(bus.done),   32'h0);
        chk("abort_result", 32'(bus.result), 32'h0);
        chk("abort_status", 32'(bus.status), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_seen), 32'h0);

        do_op(2'b00, 8'h45, 8'h67, 1'b0);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bcd_alu_seq.md
BCD_ALU_SEQ -- requirements
Module: bcd_alu_seq

Interface
REQ-001 Parameter DIGITS, default 2, sets the operand width in BCD digits; legal range is 1 to 8.
REQ-002 Port clk, input, 1 bit, the single clock; every state element is rising-edge triggered.
REQ-003 Port rst, input, 1 bit, reset; it is asynchronous and active-high.
REQ-004 Port start, input, 1 bit, request strobe; it is sampled only in IDLE.
REQ-005 Port op, input, 2 bits, operation select: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-006 Port a, input, 4*DIGITS bits, BCD operand A, packed with the most significant digit in the top nibble.
REQ-007 Port b, input, 4*DIGITS bits, BCD operand B, packed the same way as a.
REQ-008 Port result, output, 8*DIGITS bits, the registered BCD result.
REQ-009 Port status, output, 1 bit, the registered flag for carry, borrow, overflow or error.
REQ-010 Port busy, output, 1 bit, high while an operation is in progress.
REQ-011 Port done, output, 1 bit, a one-cycle pulse marking that result and status are newly valid.

Function
REQ-012 The block SHALL have the states IDLE, ADDSUB, MUL_SHIFT, MUL_ADD, DIV_SHIFT, DIV_SUB and DONE.
REQ-013 When start=1 in IDLE, the block SHALL latch op, a and b and move to the first state of the selected operation.
REQ-014 A start pulse outside IDLE SHALL be ignored, and the latched operands SHALL NOT change.
REQ-015 busy SHALL equal 1 in every state except IDLE and DONE.
REQ-016 done SHALL be 1 only in DONE, and DONE SHALL go to IDLE unconditionally after one cycle.
REQ-017 result and status SHALL be updated only on entry to DONE and SHALL hold their values until the next entry to DONE.
REQ-018 If any latched nibble of a or b exceeds 9, the block SHALL go straight to DONE with result set to all ones and status=1.
REQ-019 Add SHALL spend one cycle in ADDSUB; result is the DIGITS-digit BCD sum, zero-extended, and status is the decimal carry out.
REQ-020 Subtract SHALL spend one cycle in ADDSUB; result is |A-B| in BCD, zero-extended, and status=1 exactly when A<B.
REQ-021 Multiply SHALL process B one digit at a time, most significant digit first.
REQ-022 Per multiply digit, MUL_SHIFT SHALL spend one cycle shifting the 2*DIGITS-digit accumulator left by one decimal digit.
REQ-023 Per multiply digit d, MUL_ADD SHALL then spend d cycles, each adding A to the accumulator.
REQ-024 Multiply result SHALL be the full 2*DIGITS-digit product, with status=1 when the upper DIGITS digits are nonzero.
REQ-025 Divide with B=0 SHALL go straight to DONE with result set to all ones and status=1.
REQ-026 Divide SHALL process A one digit at a time, most significant digit first.
REQ-027 Per divide digit, DIV_SHIFT SHALL spend one cycle forming rem = rem*10 + digit, with rem held as DIGITS+1 digits.
REQ-028 Per divide digit, DIV_SUB SHALL spend one cycle per successful trial subtraction (rem >= B) and increment the quotient digit each time.
REQ-029 Per divide digit, DIV_SUB SHALL spend one further cycle when the trial fails, then advance to the next digit.
REQ-030 Divide result SHALL be {remainder, quotient}, each DIGITS digits, with status=0.
REQ-031 Latency, counted from the start-sampling edge to done=1, SHALL be as follows:
- add and subtract: 2 cycles;
- multiply: DIGITS + (sum of B's digits) + 1 cycles;
- divide: 2*DIGITS + (sum of the quotient's digits) + 1 cycles;
- error cases (REQ-018, REQ-025): 1 cycle.
REQ-032 All BCD arithmetic SHALL use ripple BCD digit adders; a binary multiplier or divider SHALL NOT be used.

Reset
REQ-033 While rst=1, the state SHALL be IDLE and result, status, busy and done SHALL all be 0, regardless of clk.
REQ-034 Assertion of rst during any operation SHALL abort it, and no done pulse SHALL follow that operation.
REQ-035 After rst is released, the first start SHALL be accepted on the first rising edge at which start=1.

Structure
REQ-036 Package bcd_alu_pkg SHALL hold the op encodings, the state enum and the error fill constant.
REQ-037 Sub-module bcd_digit_add SHALL implement a one-digit BCD adder with carry in and carry out, plus a subtract mode using the nines' complement.
REQ-038 A single chain of bcd_digit_add, 2*DIGITS instances long, SHALL be shared by all four operations.

Verification (DIGITS=2)
REQ-039 Scenario add: op=00, a=0x45, b=0x67 -> result=0x0012, status=1, done 2 cycles after start.
REQ-040 Scenario subtract: op=01, a=0x23, b=0x58 -> result=0x0035, status=1; then a=0x58, b=0x23 -> result=0x0035, status=0.
REQ-041 Scenario multiply: op=10, a=0x12, b=0x34 -> result=0x0408, status=1, done 10 cycles after start, busy high for 9 cycles.
REQ-042 Scenario divide:
- op=11, a=0x99, b=0x07 -> result=0x0114, status=0, done 10 cycles after start;
- a=0x99, b=0x00 -> result=0xFFFF, status=1, done 1 cycle after start.
REQ-043 Scenario error: op=00, a=0x1A -> result=0xFFFF, status=1, done 1 cycle after start.
REQ-044 Scenario abort: start a multiply, pulse start again mid-operation (it is ignored), then assert rst mid-multiply -> busy, done and result go to 0 immediately, and no done pulse follows.
